// File: rtl/game_timer_bcd_pkg.sv
// Shared definitions for the elapsed-play timer: FSM encoding, BCD digit limits
// and the {dozens, unity} packing used on the time outputs.
package game_timer_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_SAT    = 2'd3
  } timer_state_t;

  localparam int TIMER_MAX_DOZENS = 5;
  localparam int TIMER_MAX_UNITY  = 9;

  localparam int DOZ_W   = 3;
  localparam int UNI_W   = 4;
  localparam int FIELD_W = DOZ_W + UNI_W;

  // Field layout: [6:4] dozens, [3:0] unity.
  function automatic logic [FIELD_W-1:0] pack_field(input logic [DOZ_W-1:0] dozens,
                                                    input logic [UNI_W-1:0] unity);
    return {dozens, unity};
  endfunction

endpackage

// File: rtl/game_timer_bcd_bcd_digit_counter.sv
// One BCD digit that wraps from MAX to 0; carry is asserted combinationally on
// the increment that wraps, so digits can be chained.
module bcd_digit_counter #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] digit,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_digit;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_digit <= '0;
    end else if (inc) begin
      r_digit <= (r_digit == MAX_V) ? '0 : r_digit + W'(1);
    end
  end

  assign digit = r_digit;
  assign carry = inc && (r_digit == MAX_V);

endmodule

// File: rtl/game_timer_bcd.sv
// Elapsed-play timer: counts whole seconds 00:00..59:59 in packed BCD, with
// start/stop/clear control and a saturating end state.
module game_timer_bcd
  import game_timer_bcd_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 65_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  output logic [FIELD_W-1:0] minutes_dozens_unity,
  output logic [FIELD_W-1:0] seconds_dozens_unity,
  output logic               running,
  output logic               sec_tick,
  output logic               saturated
);

  localparam int            PW         = $clog2(CLK_FREQ_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ_HZ - 1);

  timer_state_t  r_state;
  logic [PW-1:0] r_presc;
  logic          r_sec_tick;
  logic          r_running;
  logic          r_saturated;

  logic [UNI_W-1:0] w_sec_u;
  logic [DOZ_W-1:0] w_sec_d;
  logic [UNI_W-1:0] w_min_u;
  logic [DOZ_W-1:0] w_min_d;
  logic             w_c_sec_u;
  logic             w_c_sec_d;
  logic             w_c_min_u;
  logic             w_unused_carry;

  logic w_tc;
  logic w_at_max;
  logic w_inc;

  assign w_tc     = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
  assign w_at_max = (w_sec_u == UNI_W'(TIMER_MAX_UNITY))  && (w_sec_d == DOZ_W'(TIMER_MAX_DOZENS)) &&
                    (w_min_u == UNI_W'(TIMER_MAX_UNITY))  && (w_min_d == DOZ_W'(TIMER_MAX_DOZENS));
  // At 59:59 the terminal count must not wrap the chain back to 00:00.
  assign w_inc    = w_tc && !w_at_max && !clear;

  bcd_digit_counter #(.W(UNI_W), .MAX(TIMER_MAX_UNITY)) u_sec_unity (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (w_inc),
    .digit (w_sec_u),
    .carry (w_c_sec_u)
  );

  bcd_digit_counter #(.W(DOZ_W), .MAX(TIMER_MAX_DOZENS)) u_sec_dozens (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (w_c_sec_u),
    .digit (w_sec_d),
    .carry (w_c_sec_d)
  );

  bcd_digit_counter #(.W(UNI_W), .MAX(TIMER_MAX_UNITY)) u_min_unity (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (w_c_sec_d),
    .digit (w_min_u),
    .carry (w_c_min_u)
  );

  bcd_digit_counter #(.W(DOZ_W), .MAX(TIMER_MAX_DOZENS)) u_min_dozens (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (w_c_min_u),
    .digit (w_min_d),
    .carry (w_unused_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_sec_tick  <= 1'b0;
      r_running   <= 1'b0;
      r_saturated <= 1'b0;
    end else begin
      r_sec_tick <= 1'b0;
      if (clear) begin
        r_state     <= ST_IDLE;
        r_presc     <= '0;
        r_running   <= 1'b0;
        r_saturated <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state   <= ST_RUN;
              r_presc   <= '0;
              r_running <= 1'b1;
            end
          end
          ST_PAUSED: begin
            if (start) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_tc) begin
              r_presc <= '0;
              if (w_at_max) begin
                r_state     <= ST_SAT;
                r_running   <= 1'b0;
                r_saturated <= 1'b1;
              end else begin
                r_sec_tick <= 1'b1;
                if (stop) begin
                  r_state   <= ST_PAUSED;
                  r_running <= 1'b0;
                end
              end
            end else begin
              // The stop cycle itself is still a RUN cycle, so it advances.
              r_presc <= r_presc + PW'(1);
              if (stop) begin
                r_state   <= ST_PAUSED;
                r_running <= 1'b0;
              end
            end
          end
          ST_SAT: begin
          end
        endcase
      end
    end
  end

  assign minutes_dozens_unity = pack_field(w_min_d, w_min_u);
  assign seconds_dozens_unity = pack_field(w_sec_d, w_sec_u);
  assign running              = r_running;
  assign sec_tick             = r_sec_tick;
  assign saturated            = r_saturated;

endmodule
